// File: rtl/if_id_buffer.sv
// if_id_buffer: elastic FIFO between instruction fetch and decode.
// Captures {pc, instr} pairs on a valid/ready handshake and presents them
// in order to decode. Flush empties the buffer for redirects. When empty, a
// canonical NOP with pc=0 is shown. All outputs are registered and there is
// no combinational path from inputs to outputs.
//
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   in_valid/in_ready  fetch-side handshake; in_pc/in_instr are the payload
//   out_valid/out_ready decode-side handshake; out_pc/out_instr are the head
//   flush              discard all entries; in-flight push/pop are ignored
//   count              current occupancy (0..DEPTH)
module if_id_buffer #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0]   count_nxt;
  logic            push, pop;
  logic            valid_nxt, ready_nxt;
  logic [XLEN-1:0] pc_nxt, instr_nxt;

  // Next-state: pointers, occupancy and the head value to register.
  always_comb begin
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    pc_nxt    = '0;
    instr_nxt = NOP_INSTR;

    if (flush) begin
      rd_nxt    = '0;
      wr_nxt    = '0;
      count_nxt = '0;
    end else begin
      if (push) wr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_nxt = rd_ptr + AW'(1);
      count_nxt = count + CW'(push) - CW'(pop);
    end

    valid_nxt = (count_nxt != '0);
    ready_nxt = (count_nxt < CW'(DEPTH));

    // The next head may be the slot being written this cycle (buffer was
    // empty, or its last entry is popped), so take it from the input.
    if (valid_nxt) begin
      if (push && (wr_ptr == rd_nxt)) begin
        pc_nxt    = in_pc;
        instr_nxt = in_instr;
      end else begin
        pc_nxt    = mem_pc[rd_nxt];
        instr_nxt = mem_instr[rd_nxt];
      end
    end
  end

  // Storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_pc    <= '0;
      out_instr <= NOP_INSTR;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= count_nxt;
      out_valid <= valid_nxt;
      in_ready  <= ready_nxt;
      out_pc    <= pc_nxt;
      out_instr <= instr_nxt;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_if_id_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, out_valid, out_ready, flush;
  logic [XLEN-1:0] in_pc, in_instr, out_pc, out_instr;
  logic [CW-1:0]   count;

  int checks = 0;
  int failures = 0;

  entry_t q[$];

  if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO semantics applied at each rising edge.
  task automatic model_update();
    bit do_push, do_pop;
    if (!rst_n) begin
      q.delete();
      return;
    end
    if (flush) begin
      q.delete();
      return;
    end
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{pc: in_pc, instr: in_instr});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] exp_pc();
    return (q.size() != 0) ? q[0].pc : '0;
  endfunction

  function automatic logic [XLEN-1:0] exp_instr();
    return (q.size() != 0) ? q[0].instr : NOP;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    if (out_instr !== NOP) begin failures++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
    if (out_pc !== '0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_pass_through();
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0050_0093; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%0b exp=1", out_valid); end
    if (out_pc !== 32'h100) begin failures++; $display("FAIL pass_pc got=%h exp=00000100", out_pc); end
    if (out_instr !== 32'h0050_0093) begin failures++; $display("FAIL pass_instr got=%h exp=00500093", out_instr); end
    tick();
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL pass_drain_valid got=%0b exp=0", out_valid); end
    if (count !== '0) begin failures++; $display("FAIL pass_drain_count got=%0d exp=0", count); end
    if (out_instr !== NOP) begin failures++; $display("FAIL pass_drain_instr got=%h exp=%h", out_instr, NOP); end
  endtask

  task automatic test_stall_fill();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h0; in_instr = 32'hA000_0000; tick();
    in_pc = 32'h4; in_instr = 32'hA000_0004; tick();
    checks += 3;
    if (count !== CW'(2)) begin failures++; $display("FAIL fill_count got=%0d exp=2", count); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL fill_head got=%h exp=0", out_pc); end
    in_pc = 32'h8; in_instr = 32'hA000_0008; tick();
    checks += 2;
    if (count !== CW'(2)) begin failures++; $display("FAIL fill_hold_count got=%0d exp=2", count); end
    if (out_instr !== 32'hA000_0000) begin failures++; $display("FAIL fill_stall_stable got=%h exp=a0000000", out_instr); end
    out_ready = 1'b1; tick();
    checks += 2;
    if (count !== CW'(1)) begin failures++; $display("FAIL drain1_count got=%0d exp=1", count); end
    if (out_pc !== 32'h4) begin failures++; $display("FAIL drain1_head got=%h exp=4", out_pc); end
    tick();
    in_valid = 1'b0;
    checks += 2;
    if (count !== CW'(1)) begin failures++; $display("FAIL drain2_count got=%0d exp=1", count); end
    if (out_pc !== 32'h8) begin failures++; $display("FAIL drain2_head got=%h exp=8", out_pc); end
    tick();
    checks++;
    if (count !== '0) begin failures++; $display("FAIL drain3_count got=%0d exp=0", count); end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h20; in_instr = 32'hB0; tick();
    in_pc = 32'h24; in_instr = 32'hB4; tick();
    in_pc = 32'h28; in_instr = 32'hB8; out_ready = 1'b1; tick();
    checks += 3;
    if (count !== CW'(1)) begin failures++; $display("FAIL fullpp_count got=%0d exp=1", count); end
    if (out_pc !== 32'h24) begin failures++; $display("FAIL fullpp_head got=%h exp=24", out_pc); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpp_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b0; tick();
    in_valid = 1'b0;
    checks += 2;
    if (count !== CW'(2)) begin failures++; $display("FAIL fullpp_refill_count got=%0d exp=2", count); end
    if (out_pc !== 32'h24) begin failures++; $display("FAIL fullpp_refill_head got=%h exp=24", out_pc); end
    out_ready = 1'b1; tick();
    checks++;
    if (out_instr !== 32'hB8) begin failures++; $display("FAIL fullpp_second got=%h exp=b8", out_instr); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h10; in_instr = 32'h10; tick();
    in_pc = 32'h14; in_instr = 32'h14; tick();
    in_pc = 32'h18; in_instr = 32'h18; flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; out_ready = 1'b0;
    checks += 4;
    if (count !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    if (out_instr !== NOP) begin failures++; $display("FAIL flush_instr got=%h exp=%h", out_instr, NOP); end
    if (out_pc !== '0) begin failures++; $display("FAIL flush_pc got=%h exp=0", out_pc); end
    in_pc = 32'h200; in_instr = 32'h0000_0013; tick();
    in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL postflush_valid got=%0b exp=1", out_valid); end
    if (out_pc !== 32'h200) begin failures++; $display("FAIL postflush_pc got=%h exp=200", out_pc); end
    if (count !== CW'(1)) begin failures++; $display("FAIL postflush_count got=%0d exp=1", count); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stream_wrap();
    logic [XLEN-1:0] got[$];
    int idx = 0;
    int cyc = 0;
    while ((got.size() < 20) && (cyc < 200)) begin
      in_valid  = (idx < 20);
      in_pc     = XLEN'(idx * 4);
      in_instr  = 32'hC000_0000 | XLEN'(idx);
      out_ready = (cyc % 2 == 0);
      if (out_valid && out_ready) got.push_back(out_pc);
      if (in_valid && (q.size() < DEPTH)) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got.size() != 20) begin
      failures++; $display("FAIL stream_len got=%0d exp=20", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== XLEN'(i * 4)) begin
        failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], XLEN'(i * 4));
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h300; in_instr = 32'hD0; tick();
    in_pc = 32'h304; in_instr = 32'hD4; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
    if (out_pc !== '0) begin failures++; $display("FAIL arst_pc got=%h exp=0", out_pc); end
    if (out_instr !== NOP) begin failures++; $display("FAIL arst_instr got=%h exp=%h", out_instr, NOP); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%0b exp=1", in_ready); end
    if (count !== '0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (count !== '0) begin failures++; $display("FAIL arst_release_count got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if ((out_valid !== (q.size() != 0)) || (count !== CW'(q.size())) ||
          (in_ready !== (q.size() < DEPTH)) || (out_pc !== exp_pc()) ||
          (out_instr !== exp_instr())) begin
        failures++;
        $display("FAIL random cyc=%0d got v=%0b r=%0b n=%0d pc=%h i=%h exp v=%0b r=%0b n=%0d pc=%h i=%h",
                 c, out_valid, in_ready, count, out_pc, out_instr,
                 (q.size() != 0), (q.size() < DEPTH), q.size(), exp_pc(), exp_instr());
      end
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall_fill();
    test_full_push_pop();
    test_flush();
    test_stream_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
